// File: rtl/mem_bridge_if.sv
// mem_bridge_if
//   Bundles the CPU M-stage memory port and the slave bus of mem_bridge.
//   Signal names follow the bridge's external port list.
//   Modports:
//     master : bridge view. It drives the slave bus and the CPU return path.
//     slave  : environment view (CPU + slaves). It drives the request, acks and read data.
//   CPU side  : cpu_req/we/addr/byteen/wdata in, cpu_rdata/stall/err/excCode out
//   Slave side: s_sel/addr/we/byteen/wdata out, s_ack + {dm,t0,t1,ig}_rdata in
interface mem_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic [4:0]  cpu_excCode;
    logic [3:0]  s_sel;
    logic [31:0] s_addr;
    logic        s_we;
    logic [3:0]  s_byteen;
    logic [31:0] s_wdata;
    logic [3:0]  s_ack;
    logic [31:0] dm_rdata;
    logic [31:0] t0_rdata;
    logic [31:0] t1_rdata;
    logic [31:0] ig_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_err, cpu_excCode,
        output s_sel, s_addr, s_we, s_byteen, s_wdata,
        input  s_ack, dm_rdata, t0_rdata, t1_rdata, ig_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_err, cpu_excCode,
        input  s_sel, s_addr, s_we, s_byteen, s_wdata,
        output s_ack, dm_rdata, t0_rdata, t1_rdata, ig_rdata
    );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge
//   Multi-cycle bridge from the CPU M-stage memory port to DM, Timer0,
//   Timer1 and the interrupt generator. Each request is decoded in IDLE.
//   A legal request drives one slave in ACCESS until that slave acks, then
//   completes in DONE. An illegal request, or a slave that never answers,
//   ends in a one-cycle ERR with excCode 4 (load) / 5 (store).
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-low
//     bus    : mem_bridge_if.master (CPU port + slave bus)
//   Parameter:
//     TIMEOUT: ACCESS cycles to wait for ack before ERR (1..15)
//   Build option:
//     BRIDGE_TIMEOUT_EN: when defined, the ack timeout is built in. When it
//     is undefined, ACCESS waits forever and TIMEOUT is ignored.
module mem_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t      stateQ, stateD;

    logic [3:0]  selQ, selD;
    logic [31:0] addrQ, wdataQ, rdataQ;
    logic        weQ;
    logic [3:0]  byteenQ;
    logic        errQ, errD;
    logic [4:0]  excQ, excD;
    logic        latchReq, captureRdata;

    // ---------------- request decode ----------------
    logic        isDm, isT0, isT1, isIg;
    logic        isWord, isHalf, isByte;
    logic        badEnc, badAlign, badWidth, badStore, reqLegal;
    logic [3:0]  decSel;

    always_comb begin
        isDm   = bus.cpu_addr < 32'h0000_3000;
        // Timer windows are 12 bytes: the fourth word of each 16-byte block is unmapped.
        isT0   = (bus.cpu_addr[31:4] == 28'h00007f0) && (bus.cpu_addr[3:2] != 2'd3);
        isT1   = (bus.cpu_addr[31:4] == 28'h00007f1) && (bus.cpu_addr[3:2] != 2'd3);
        isIg   = (bus.cpu_addr[31:2] == 30'h00001fc8);
        decSel = {isIg, isT1, isT0, isDm};

        isWord = (bus.cpu_byteen == 4'b1111);
        isHalf = (bus.cpu_byteen == 4'b0011) || (bus.cpu_byteen == 4'b1100);
        isByte = (bus.cpu_byteen == 4'b0001) || (bus.cpu_byteen == 4'b0010) ||
                 (bus.cpu_byteen == 4'b0100) || (bus.cpu_byteen == 4'b1000);
        // Enable patterns the CPU never issues are rejected, not forwarded.
        badEnc   = !(isWord || isHalf || isByte);
        badAlign = (isWord && (bus.cpu_addr[1:0] != 2'd0)) || (isHalf && bus.cpu_addr[0]);
        badWidth = (isT0 || isT1 || isIg) && !isWord;
        // The timer COUNT register is read-only.
        badStore = (isT0 || isT1) && bus.cpu_we && (bus.cpu_addr[3:2] == 2'd2);
        reqLegal = (|decSel) && !badEnc && !badAlign && !badWidth && !badStore;
    end

    // ---------------- selected-slave return path ----------------
    logic        selAck;
    logic [31:0] selRdata;

    always_comb begin
        selAck   = |(bus.s_ack & selQ);
        selRdata = 32'h0;
        if (selQ[0])      selRdata = bus.dm_rdata;
        else if (selQ[1]) selRdata = bus.t0_rdata;
        else if (selQ[2]) selRdata = bus.t1_rdata;
        else if (selQ[3]) selRdata = bus.ig_rdata;
    end

    // ---------------- ack timeout ----------------
    logic timeoutHit;

`ifdef BRIDGE_TIMEOUT_EN
    logic [3:0] cnt;

    // cnt counts the ACCESS cycles already spent without ack. When it
    // reaches TIMEOUT-1 in an ack-less cycle, that cycle is the TIMEOUT-th
    // one and the bridge gives up.
    assign timeoutHit = (cnt == 4'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          cnt <= 4'd0;
        else if (stateQ == IDLE)             cnt <= 4'd0;
        else if (stateQ == ACCESS && !selAck) cnt <= cnt + 4'd1;
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
    assign timeoutHit    = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (bus.cpu_req) stateD = reqLegal ? ACCESS : ERR;
            ACCESS:  if (selAck)          stateD = DONE;
                     else if (timeoutHit) stateD = ERR;
            DONE:    stateD = IDLE;
            ERR:     stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / register next-values ----------------
    always_comb begin
        selD         = 4'd0;
        errD         = 1'b0;
        excD         = 5'd0;
        latchReq     = 1'b0;
        captureRdata = 1'b0;
        case (stateQ)
            IDLE: if (bus.cpu_req) begin
                if (reqLegal) begin
                    selD     = decSel;
                    latchReq = 1'b1;
                end else begin
                    errD = 1'b1;
                    excD = bus.cpu_we ? 5'd5 : 5'd4;
                end
            end
            ACCESS: begin
                if (selAck) begin
                    captureRdata = 1'b1;
                end else if (timeoutHit) begin
                    errD = 1'b1;
                    excD = weQ ? 5'd5 : 5'd4;
                end else begin
                    selD = selQ;
                end
            end
            default: ;
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req && (stateQ == IDLE || stateQ == ACCESS);

    // ---------------- registered datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            selQ    <= 4'd0;
            addrQ   <= 32'h0;
            weQ     <= 1'b0;
            byteenQ <= 4'd0;
            wdataQ  <= 32'h0;
            rdataQ  <= 32'h0;
            errQ    <= 1'b0;
            excQ    <= 5'd0;
        end else begin
            selQ <= selD;
            errQ <= errD;
            excQ <= excD;
            if (latchReq) begin
                addrQ   <= bus.cpu_addr;
                weQ     <= bus.cpu_we;
                byteenQ <= bus.cpu_byteen;
                wdataQ  <= bus.cpu_wdata;
            end
            if (captureRdata) rdataQ <= selRdata;
        end
    end

    assign bus.s_sel       = selQ;
    assign bus.s_addr      = addrQ;
    assign bus.s_we        = weQ;
    assign bus.s_byteen    = byteenQ;
    assign bus.s_wdata     = wdataQ;
    assign bus.cpu_rdata   = rdataQ;
    assign bus.cpu_err     = errQ;
    assign bus.cpu_excCode = excQ;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
//   Directed, table-driven bench for mem_bridge. Each table record is one
//   CPU access, with the slave's ack delay and the expected outcome. Hand
//   sequences cover the ack timeout (or the lack of one) and reset in the
//   middle of an access.
module tb_mem_bridge;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_bridge_if bus ();

    mem_bridge #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
        int          delay;    // ack-less ACCESS cycles before the ack
        logic [31:0] rdata;    // data returned by the selected slave
        logic        expErr;
        logic [4:0]  expCode;
        logic [3:0]  expSel;
    } vec_t;

    localparam int NV = 15;
    vec_t        vecs [NV];
    int          nChecks = 0;
    int          nFail   = 0;
    logic [31:0] lastRdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Put val on the selected slave's bus and its complement on the others.
    task automatic setRdata(input logic [3:0] sel, input logic [31:0] val);
        bus.dm_rdata = sel[0] ? val : ~val;
        bus.t0_rdata = sel[1] ? val : ~val;
        bus.t1_rdata = sel[2] ? val : ~val;
        bus.ig_rdata = sel[3] ? val : ~val;
    endtask

    // Called at a negedge with the bridge in IDLE. Returns at a negedge in IDLE.
    task automatic applyVec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = v.we;
        bus.cpu_addr   = v.addr;
        bus.cpu_byteen = v.byteen;
        bus.cpu_wdata  = v.wdata;
        #1 chk({t, " stall_idle"}, 32'(bus.cpu_stall), 32'd1);
        @(negedge clk);
        if (v.expErr) begin
            chk({t, " err"},    32'(bus.cpu_err),     32'd1);
            chk({t, " code"},   32'(bus.cpu_excCode), 32'(v.expCode));
            chk({t, " sel0"},   32'(bus.s_sel),       32'd0);
            chk({t, " stall0"}, 32'(bus.cpu_stall),   32'd0);
            chk({t, " rdata_hold"}, bus.cpu_rdata,    lastRdata);
            bus.cpu_req = 1'b0;
            @(negedge clk);
            chk({t, " err_pulse"}, {27'd0, bus.cpu_excCode} | 32'(bus.cpu_err), 32'd0);
        end else begin
            for (int k = 0; k <= v.delay; k++) begin
                chk({t, " sel"},   32'(bus.s_sel),     32'(v.expSel));
                chk({t, " stall"}, 32'(bus.cpu_stall), 32'd1);
                if (k == 0) begin
                    chk({t, " s_addr"},   bus.s_addr,           v.addr);
                    chk({t, " s_we"},     32'(bus.s_we),        32'(v.we));
                    chk({t, " s_byteen"}, 32'(bus.s_byteen),    32'(v.byteen));
                    chk({t, " s_wdata"},  bus.s_wdata,          v.wdata);
                end
                // Wait cycles carry acks on the other slaves only; they must be ignored.
                bus.s_ack = (k == v.delay) ? v.expSel : (~v.expSel & 4'hF);
                setRdata(v.expSel, v.rdata);
                @(negedge clk);
            end
            chk({t, " done_stall"}, 32'(bus.cpu_stall), 32'd0);
            chk({t, " done_sel"},   32'(bus.s_sel),     32'd0);
            chk({t, " done_err"},   32'(bus.cpu_err),   32'd0);
            chk({t, " rdata"},      bus.cpu_rdata,      v.rdata);
            lastRdata   = v.rdata;
            bus.cpu_req = 1'b0;
            bus.s_ack   = 4'd0;
            @(negedge clk);
        end
    endtask

    initial begin
        //          we    addr          be       wdata         dly rdata         err   code  sel
        vecs[0]  = '{1'b0, 32'h0000_1004, 4'hF,    32'h0,        1, 32'hDEAD_BEEF, 1'b0, 5'd0, 4'b0001};
        vecs[1]  = '{1'b1, 32'h0000_7f14, 4'hF,    32'h10,       0, 32'h0000_0005, 1'b0, 5'd0, 4'b0100};
        vecs[2]  = '{1'b0, 32'h0000_7f20, 4'hF,    32'h0,        2, 32'h0000_0001, 1'b0, 5'd0, 4'b1000};
        vecs[3]  = '{1'b0, 32'h0000_7f04, 4'hF,    32'h0,        0, 32'h0000_1234, 1'b0, 5'd0, 4'b0010};
        vecs[4]  = '{1'b1, 32'h0000_2fff, 4'b1000, 32'hAB00_0000, 0, 32'h0000_0000, 1'b0, 5'd0, 4'b0001};
        vecs[5]  = '{1'b0, 32'h0000_0002, 4'b1100, 32'h0,        3, 32'hCAFE_0000, 1'b0, 5'd0, 4'b0001};
        vecs[6]  = '{1'b0, 32'h0000_7f08, 4'hF,    32'h0,        0, 32'h0000_0077, 1'b0, 5'd0, 4'b0010};
        vecs[7]  = '{1'b0, 32'h0000_3000, 4'hF,    32'h0,        0, 32'h0,         1'b1, 5'd4, 4'b0000};
        vecs[8]  = '{1'b1, 32'h0000_7f08, 4'hF,    32'h1,        0, 32'h0,         1'b1, 5'd5, 4'b0000};
        vecs[9]  = '{1'b1, 32'h0000_7f20, 4'b0011, 32'h1,        0, 32'h0,         1'b1, 5'd5, 4'b0000};
        vecs[10] = '{1'b0, 32'h0000_0002, 4'hF,    32'h0,        0, 32'h0,         1'b1, 5'd4, 4'b0000};
        vecs[11] = '{1'b1, 32'h0000_0001, 4'b0011, 32'h2,        0, 32'h0,         1'b1, 5'd5, 4'b0000};
        vecs[12] = '{1'b0, 32'h0000_7f0c, 4'hF,    32'h0,        0, 32'h0,         1'b1, 5'd4, 4'b0000};
        vecs[13] = '{1'b1, 32'h0000_7f18, 4'hF,    32'h3,        0, 32'h0,         1'b1, 5'd5, 4'b0000};
        vecs[14] = '{1'b0, 32'h0000_7f00, 4'b0001, 32'h0,        0, 32'h0,         1'b1, 5'd4, 4'b0000};

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
        bus.cpu_byteen = 4'h0; bus.cpu_wdata = 32'h0; bus.s_ack = 4'h0;
        setRdata(4'h0, 32'h0);
        lastRdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst sel",   32'(bus.s_sel),       32'd0);
        chk("rst addr",  bus.s_addr,           32'd0);
        chk("rst rdata", bus.cpu_rdata,        32'd0);
        chk("rst err",   32'(bus.cpu_err),     32'd0);
        chk("rst code",  32'(bus.cpu_excCode), 32'd0);
        chk("rst stall", 32'(bus.cpu_stall),   32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) applyVec(i, vecs[i]);

        // Timer0 that never acks
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_7f00;
        bus.cpu_byteen = 4'hF; bus.s_ack = 4'h0; setRdata(4'b0010, 32'h0000_0055);
        @(negedge clk);
`ifdef BRIDGE_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("to access%0d stall", k), 32'(bus.cpu_stall), 32'd1);
            chk($sformatf("to access%0d err", k),   32'(bus.cpu_err),   32'd0);
            @(negedge clk);
        end
        chk("to err",   32'(bus.cpu_err),     32'd1);
        chk("to code",  32'(bus.cpu_excCode), 32'd4);
        chk("to stall", 32'(bus.cpu_stall),   32'd0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
`else
        repeat (99) @(negedge clk);
        chk("nto sel",   32'(bus.s_sel),     32'd2);
        chk("nto stall", 32'(bus.cpu_stall), 32'd1);
        chk("nto err",   32'(bus.cpu_err),   32'd0);
        bus.s_ack = 4'b0010;
        @(negedge clk);
        chk("nto done_stall", 32'(bus.cpu_stall), 32'd0);
        chk("nto rdata",      bus.cpu_rdata,       32'h0000_0055);
        bus.cpu_req = 1'b0; bus.s_ack = 4'h0;
        @(negedge clk);
`endif
        lastRdata = bus.cpu_rdata;

        // Reset during ACCESS
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0010;
        bus.cpu_byteen = 4'hF; bus.cpu_wdata = 32'h1111_2222;
        @(negedge clk);
        chk("mid sel_before", 32'(bus.s_sel), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid sel",   32'(bus.s_sel),       32'd0);
        chk("mid addr",  bus.s_addr,           32'd0);
        chk("mid wdata", bus.s_wdata,          32'd0);
        chk("mid we",    32'(bus.s_we),        32'd0);
        chk("mid rdata", bus.cpu_rdata,        32'd0);
        chk("mid stall", 32'(bus.cpu_stall),   32'd1);
        bus.cpu_req = 1'b0;
        #1 chk("mid stall_req0", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lastRdata = 32'h0;
        @(negedge clk);
        applyVec(100, vecs[0]);
        applyVec(101, vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Multi-cycle system bridge between the CPU M-stage memory port and the four memory-mapped slaves: data memory (DM, 0x0000_0000–0x0000_2fff), Timer0 (0x0000_7f00–0x0000_7f0b), Timer1 (0x0000_7f10–0x0000_7f1b) and the interrupt generator (IG, 0x0000_7f20–0x0000_7f23). It decodes each request, drives exactly one slave, waits for that slave's acknowledge, stalls the pipeline meanwhile, and returns read data or an address-error exception code (4 = AdEL, 5 = AdES). It sits between the M stage and the slave modules, upstream of the CP0 exception mux.

## Interface
- TIMEOUT, 15: cycles to wait for the selected slave's ack before raising an error (4-bit counter; legal range 1..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage access request; held stable while cpu_stall=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_byteen  in  4  byte enables: 4'b1111 word, 4'b0011/4'b1100 half, one-hot byte.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid in the completion cycle.
- cpu_stall  out  1  freeze F/D/E/M while high.
- cpu_err  out  1  one-cycle error pulse in place of completion.
- cpu_excCode  out  5  4 or 5 when cpu_err=1, else 0.
- s_sel  out  4  one-hot slave select {IG, T1, T0, DM}.
- s_addr  out  32  registered request address.
- s_we  out  1  registered write strobe.
- s_byteen  out  4  registered byte enables.
- s_wdata  out  32  registered store data.
- s_ack  in  4  per-slave acknowledge, same bit order as s_sel.
- dm_rdata, t0_rdata, t1_rdata, ig_rdata  in  32 each  slave read data, valid with the matching ack.

## Operation
- States: IDLE, ACCESS, DONE, ERR. Reset: IDLE. All outputs 0: s_sel=0, s_* registers 0, cpu_rdata=0, cpu_err=0, cpu_excCode=0. Timeout counter=0.
- IDLE: if cpu_req=0, stay. If cpu_req=1, decode the request:
  - Legal: go to ACCESS. Latch cpu_addr, cpu_we, cpu_byteen and cpu_wdata into the s_* registers. Set s_sel one-hot. Clear the counter.
  - Illegal: go to ERR. Latch excCode = cpu_we ? 5 : 4.
- Illegal request conditions:
  - Address outside all four ranges.
  - Misalignment: word with addr[1:0]≠0, or half with addr[0]≠0.
  - Non-word access (byteen≠4'b1111) to T0, T1 or IG.
  - Store to a timer COUNT register (offset 8, addr[3:2]=2'd2).
- ACCESS:
  - Selected ack=1: capture the matching rdata into cpu_rdata and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to ERR with excCode = s_we ? 5 : 4.
  - Acks on non-selected bits are ignored.
- DONE: hold for one cycle, then go to IDLE. s_sel=0.
- ERR: cpu_err=1 for one cycle, then go to IDLE. s_sel=0. cpu_rdata unchanged.
- cpu_stall = cpu_req & (state==IDLE | state==ACCESS).
  - Deasserts in DONE/ERR; that cycle the pipeline advances.
  - A request still high in the following IDLE cycle is a new access.
- A store is committed by the slave on its ack cycle. The bridge never retries.
- Reset mid-operation returns to IDLE immediately, drops s_sel and clears all outputs.

## Timing
- Legal access, slave acks in the first ACCESS cycle: 3 cycles from the request in IDLE to the pipeline advancing. That is IDLE(decode), ACCESS(ack), DONE(stall=0).
- Each slave wait cycle adds 1 cycle.
- Decode error: 2 cycles, IDLE then ERR.
- Timeout error: 1 + TIMEOUT + 1 cycles.
- cpu_rdata is registered and valid only in DONE. cpu_err and cpu_excCode are registered.
- s_* outputs are stable for the whole ACCESS state.

## Configuration
- BRIDGE_TIMEOUT_EN defined: the timeout counter and the timeout→ERR transition are present as specified.
- BRIDGE_TIMEOUT_EN undefined: the counter logic is removed. ACCESS waits indefinitely for ack, and errors come only from decode. The TIMEOUT parameter is ignored.

## Test plan
- DM word load: addr=0x0000_1004, byteen=4'hF, DM acks in the 2nd ACCESS cycle with 0xDEAD_BEEF -> stall high for 3 cycles, then DONE with cpu_rdata=0xDEAD_BEEF, s_sel=4'b0001, cpu_err=0.
- Timer1 store: addr=0x0000_7f14, wdata=0x10, immediate ack -> s_sel=4'b0100, s_we=1, s_wdata=0x10 held through ACCESS; completion in DONE with no error.
- Decode errors:
  - Load from addr=0x0000_3000 -> ERR next cycle, cpu_err=1, excCode=4, s_sel never nonzero.
  - Store to 0x0000_7f08 -> excCode=5.
  - Halfword store to 0x0000_7f20 -> excCode=5.
- Misalignment: word load at addr=0x0000_0002 -> excCode=4. Half store at addr=0x0000_0001 -> excCode=5.
- Timeout (macro defined, TIMEOUT=15): load to 0x0000_7f00 with T0 never acking -> ERR after 15 ACCESS cycles, excCode=4. Same run with macro undefined -> still in ACCESS after 100 cycles; a later ack completes normally.
- Reset: drive reset=0 during ACCESS -> asynchronously IDLE, s_sel=0, cpu_stall follows cpu_req, all registered outputs 0; the next request decodes normally.
